neuron_requant_stage: RTL and testbench
=======================================

NEURON_REQUANT_STAGE -- requirements
Module: neuron_requant_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_WIDTH, 16, signed activation/weight/bias width, Q(FRAC_BITS)
  FRAC_BITS, 8, fractional bits of activation format
  NUM_NEURONS, 128, neurons per layer; index wraps after NUM_NEURONS-1
  FIFO_DEPTH, 4, output FIFO entries, power of two, >=4
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-high reset
  layer_start  in  1  pulse; restart neuron index, clear sticky flags
  acc_in  in  2*DATA_WIDTH  signed accumulator result, Q(2*FRAC_BITS)
  acc_valid  in  1  one-cycle pulse qualifying acc_in
  in_ready  out  1  high = block can accept acc_valid this cycle
  bias_wr_en  in  1  bias table write strobe
  bias_wr_addr  in  $clog2(NUM_NEURONS)  bias table address
  bias_wr_data  in  DATA_WIDTH  signed bias, Q(FRAC_BITS)
  out_data  out  DATA_WIDTH  signed requantized activation
  out_idx  out  $clog2(NUM_NEURONS)  neuron index of out_data
  out_valid  out  1  out_data/out_idx valid
  out_ready  in  1  downstream accept
  layer_done  out  1  one-cycle pulse on handshake of index NUM_NEURONS-1
  sat_flag  out  1  sticky: any result saturated
  overrun_flag  out  1  sticky: acc_valid arrived with in_ready low

Function
REQ-003 Sample accepted when acc_valid && in_ready; tagged with internal neuron index, which then increments, wrapping NUM_NEURONS-1 -> 0.
REQ-004 Stage 1: sum = sign-extended acc_in + (bias[idx] <<< FRAC_BITS), width 2*DATA_WIDTH+2, no overflow possible.
REQ-005 Stage 2: round half-up: r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift.
REQ-006 Stage 3: saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; saturation sets sat_flag; activation per REQ-016; result written to FIFO.
REQ-007 Latency: sample accepted in cycle N is written to FIFO at end of cycle N+2; visible on out_valid in cycle N+3 if FIFO was empty.
REQ-008 Pipeline never stalls; stages advance every cycle with per-stage valid bits.
REQ-009 in_ready = (fifo_count + occupied pipeline stages) < FIFO_DEPTH; guarantees FIFO never overflows.
REQ-010 acc_valid with in_ready low: sample dropped, index not advanced, overrun_flag set.
REQ-011 Output handshake: entry popped when out_valid && out_ready; out_data/out_idx held stable while out_valid && !out_ready.
REQ-012 FIFO full and empty simultaneously with push/pop: push and pop in same cycle both occur, count unchanged.
REQ-013 Bias write concurrent with a stage-1 read of same address: stage 1 uses the old value.
REQ-014 layer_start: index <- 0, sat_flag/overrun_flag <- 0; in-flight and FIFO data still delivered with original indices; concurrent acc_valid accepted as index 0; concurrent saturation sets flag (set wins).

Reset
REQ-015 On rst: pipeline valids, FIFO, index <- 0; out_valid, layer_done, sat_flag, overrun_flag <- 0; in_ready <- 1; out_data, out_idx <- 0; bias table contents not reset.

Configuration
REQ-016 Macro NEURON_RELU_EN: defined -> negative saturated results output 0x0000 (ReLU) and are not counted as saturation; undefined -> signed result passed through unchanged.

Structure
REQ-017 Shared package nn_pkg: DATA_WIDTH, FRAC_BITS, ACC_WIDTH (=2*DATA_WIDTH), SAT_MAX/SAT_MIN constants, activation typedef.
REQ-018 One sub-module: sync_fifo (parameterized width/depth, count output), instantiated for output buffering.

Verification (FRAC_BITS=8)
REQ-019 bias[0]=0x0100, acc_in=0x0001_0000 -> out_data=0x0200, out_idx=0, out_valid 3 cycles after acc_valid.
REQ-020 bias=0, acc_in=0x0000_0080 -> 0x0001 (round up); acc_in=0x0000_007F -> 0x0000.
REQ-021 acc_in=0x7FFF_0000 -> 0x7FFF, sat_flag=1; acc_in=0xFFFF_0000 -> 0x0000 with NEURON_RELU_EN, 0xFF00 without.
REQ-022 out_ready held low, acc_valid every cycle -> in_ready low after 4 accepts, 5th dropped, overrun_flag=1, no FIFO overflow; release -> 4 outputs in order.
REQ-023 NUM_NEURONS=4, 4 samples, out_ready=1 -> out_idx 0..3, layer_done pulses once with idx 3; layer_start then clears flags, next sample idx 0.
REQ-024 rst asserted mid-stream with 2 samples in flight -> next cycle out_valid=0, in_ready=1, no stale output after release.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared numeric constants and activation type for the neuron datapath.
package nn_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

  typedef logic signed [DATA_WIDTH-1:0] act_t;

  localparam act_t SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam act_t SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is presented on rd_data.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  assign full_s  = (count_r == CW'(DEPTH));
  assign empty   = (count_r == {CW{1'b0}});
  assign pop_s   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_s  = push && (!full_s || pop_s);
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/neuron_requant_stage.sv
// Bias add, round-half-up, saturate and buffer neuron accumulator results.
// Build macro NEURON_RELU_EN zeroes negative results; layer_done pulses the cycle after index NUM_NEURONS-1 is handed off.
module neuron_requant_stage #(
  parameter  int DATA_WIDTH  = nn_pkg::DATA_WIDTH,
  parameter  int FRAC_BITS   = nn_pkg::FRAC_BITS,
  parameter  int NUM_NEURONS = 128,
  parameter  int FIFO_DEPTH  = 4,
  localparam int IDX_W       = $clog2(NUM_NEURONS),
  localparam int ACC_W       = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_start,
  input  logic [ACC_W-1:0]      acc_in,
  input  logic                  acc_valid,
  output logic                  in_ready,
  input  logic                  bias_wr_en,
  input  logic [IDX_W-1:0]      bias_wr_addr,
  input  logic [DATA_WIDTH-1:0] bias_wr_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  layer_done,
  output logic                  sat_flag,
  output logic                  overrun_flag
);
  localparam int SUM_W = ACC_W + 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 2;
  localparam int FW    = DATA_WIDTH + IDX_W;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic signed [SUM_W-1:0] RND   = {{(SUM_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

  logic [DATA_WIDTH-1:0] bias_mem_r [NUM_NEURONS];
  logic [IDX_W-1:0]      idx_r;
  logic                  s1_valid_r, s2_valid_r;
  logic [ACC_W-1:0]      s1_acc_r;
  logic [DATA_WIDTH-1:0] s1_bias_r;
  logic [IDX_W-1:0]      s1_idx_r, s2_idx_r;
  logic signed [SUM_W-1:0] s2_r;
  logic                  in_ready_r, layer_done_r, sat_flag_r, overrun_flag_r;

  logic                    accept_s, pop_s, sat_s, fifo_empty_s;
  logic [IDX_W-1:0]        tag_s;
  logic signed [SUM_W-1:0] sum_s, rnd_s;
  logic [DATA_WIDTH-1:0]   res_s;
  logic [FW-1:0]           fifo_rd_s;
  logic [CNT_W-1:0]        fifo_count_s;
  logic [OCC_W-1:0]        occ_next_s;

  assign accept_s = acc_valid && in_ready_r;
  assign tag_s    = layer_start ? {IDX_W{1'b0}} : idx_r;
  assign pop_s    = out_valid && out_ready;
  assign sum_s    = $signed({{2{s1_acc_r[ACC_W-1]}}, s1_acc_r})
                  + $signed({{(SUM_W-DATA_WIDTH-FRAC_BITS){s1_bias_r[DATA_WIDTH-1]}}, s1_bias_r, {FRAC_BITS{1'b0}}});
  assign rnd_s    = (sum_s + RND) >>> FRAC_BITS;
  // Everything accepted but not yet popped, as it will stand next cycle.
  assign occ_next_s = OCC_W'(fifo_count_s) + OCC_W'(s2_valid_r) + OCC_W'(s1_valid_r)
                    + OCC_W'(accept_s) - OCC_W'(pop_s);

  // Bias table write port; the table keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bias_wr_en) begin
      bias_mem_r[bias_wr_addr] <= bias_wr_data;
    end else begin
      bias_mem_r[bias_wr_addr] <= bias_mem_r[bias_wr_addr];
    end
  end

  // Stage 3: clamp to the activation range (or ReLU) and flag saturation.
  always_comb begin
    res_s = s2_r[DATA_WIDTH-1:0];
    sat_s = 1'b0;
    if (s2_r > MAX_S) begin
      res_s = MAX_S[DATA_WIDTH-1:0];
      sat_s = s2_valid_r;
    end else if (s2_r < MIN_S) begin
`ifdef NEURON_RELU_EN
      res_s = {DATA_WIDTH{1'b0}};
`else
      res_s = MIN_S[DATA_WIDTH-1:0];
      sat_s = s2_valid_r;
`endif
    end else begin
`ifdef NEURON_RELU_EN
      if (s2_r[SUM_W-1]) begin
        res_s = {DATA_WIDTH{1'b0}};
      end else begin
        res_s = s2_r[DATA_WIDTH-1:0];
      end
`else
      res_s = s2_r[DATA_WIDTH-1:0];
`endif
    end
  end

  // Pipeline stages, neuron index, flow control and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r          <= {IDX_W{1'b0}};
      s1_valid_r     <= 1'b0;
      s1_acc_r       <= {ACC_W{1'b0}};
      s1_bias_r      <= {DATA_WIDTH{1'b0}};
      s1_idx_r       <= {IDX_W{1'b0}};
      s2_valid_r     <= 1'b0;
      s2_r           <= {SUM_W{1'b0}};
      s2_idx_r       <= {IDX_W{1'b0}};
      in_ready_r     <= 1'b1;
      layer_done_r   <= 1'b0;
      sat_flag_r     <= 1'b0;
      overrun_flag_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_acc_r  <= acc_in;
        s1_bias_r <= bias_mem_r[tag_s];
        s1_idx_r  <= tag_s;
        idx_r     <= (tag_s == LAST_IDX) ? {IDX_W{1'b0}} : tag_s + IDX_W'(1'b1);
      end else begin
        idx_r <= tag_s;
      end
      s2_valid_r     <= s1_valid_r;
      s2_r           <= rnd_s;
      s2_idx_r       <= s1_idx_r;
      in_ready_r     <= (occ_next_s < OCC_W'(FIFO_DEPTH));
      layer_done_r   <= pop_s && (out_idx == LAST_IDX);
      sat_flag_r     <= sat_s || (sat_flag_r && !layer_start);
      overrun_flag_r <= (acc_valid && !in_ready_r) || (overrun_flag_r && !layer_start);
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s2_valid_r),
    .wr_data ({res_s, s2_idx_r}),
    .pop     (pop_s),
    .rd_data (fifo_rd_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign out_valid    = !fifo_empty_s;
  assign out_data     = fifo_rd_s[FW-1:IDX_W];
  assign out_idx      = fifo_rd_s[IDX_W-1:0];
  assign in_ready     = in_ready_r;
  assign layer_done   = layer_done_r;
  assign sat_flag     = sat_flag_r;
  assign overrun_flag = overrun_flag_r;
endmodule

// File: tb/tb_neuron_requant_stage.sv
// Directed bench for neuron_requant_stage with a cycle-level reference model.
module tb_neuron_requant_stage;
  import nn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        layer_start = 1'b0;
  logic [31:0] acc_in = 32'h0;
  logic        acc_valid = 1'b0;
  logic        in_ready;
  logic        bias_wr_en = 1'b0;
  logic [1:0]  bias_wr_addr = 2'd0;
  logic [15:0] bias_wr_data = 16'h0;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        layer_done;
  logic        sat_flag;
  logic        overrun_flag;

  neuron_requant_stage #(.NUM_NEURONS(4)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .acc_in(acc_in), .acc_valid(acc_valid),
    .in_ready(in_ready), .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr),
    .bias_wr_data(bias_wr_data), .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .layer_done(layer_done), .sat_flag(sat_flag), .overrun_flag(overrun_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: bias in Q8, accumulator in Q16, result Q8.
  function automatic void model(input logic [31:0] acc, input logic [15:0] b,
                                output logic [15:0] d, output bit s);
    longint sum, r;
    sum = longint'($signed(acc)) + longint'($signed(b)) * 256;
    r = (sum + 128) >>> 8;
    s = 1'b0;
    d = r[15:0];
    if (r > 32767) begin
      d = SAT_MAX;
      s = 1'b1;
    end else if (r < -32768) begin
`ifdef NEURON_RELU_EN
      d = 16'h0000;
`else
      d = SAT_MIN;
      s = 1'b1;
`endif
    end else if (r < 0) begin
`ifdef NEURON_RELU_EN
      d = 16'h0000;
`endif
    end
  endfunction

  typedef struct {
    logic [15:0] d;
    logic [1:0]  idx;
    int          acc_cyc;
    bit          sat;
  } ent_t;

  ent_t        q[$];
  logic [15:0] obs_d[$];
  logic [1:0]  obs_i[$];
  logic [15:0] bias_m [4];
  int          cyc = 0;
  int          ld_cnt = 0;
  bit          mv = 1'b0, just_rst = 1'b0;
  bit          m_sat, m_ovr, m_ld, e_ir, e_ov, sat_set, pop_m;
  logic [1:0]  m_idx, tag;
  ent_t        e;

  // Compare DUT against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    cyc++;
    e_ir = (q.size() < 4);
    e_ov = (q.size() > 0) && (q[0].acc_cyc + 3 <= cyc);
    if (mv) begin
      chk("in_ready", in_ready, e_ir);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) begin
        chk("out_data", out_data, q[0].d);
        chk("out_idx", out_idx, q[0].idx);
      end
      chk("sat_flag", sat_flag, m_sat);
      chk("overrun_flag", overrun_flag, m_ovr);
      chk("layer_done", layer_done, m_ld);
      if (just_rst) begin
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_idx", out_idx, 2'd0);
      end
    end
    if (layer_done) ld_cnt++;
    if (!rst && out_valid && out_ready) begin
      obs_d.push_back(out_data);
      obs_i.push_back(out_idx);
    end
    if (rst) begin
      q.delete();
      m_idx = 2'd0; m_sat = 1'b0; m_ovr = 1'b0; m_ld = 1'b0;
      mv = 1'b1; just_rst = 1'b1;
    end else if (mv) begin
      just_rst = 1'b0;
      sat_set = 1'b0;
      foreach (q[i]) if (q[i].acc_cyc == cyc - 2 && q[i].sat) sat_set = 1'b1;
      pop_m = e_ov && out_ready;
      m_ld = 1'b0;
      if (pop_m) begin
        m_ld = (q[0].idx == 2'd3);
        void'(q.pop_front());
      end
      if (acc_valid && e_ir) begin
        tag = layer_start ? 2'd0 : m_idx;
        model(acc_in, bias_m[tag], e.d, e.sat);
        e.idx = tag;
        e.acc_cyc = cyc;
        q.push_back(e);
        m_idx = tag + 2'd1;
      end else if (layer_start) begin
        m_idx = 2'd0;
      end
      m_ovr = (acc_valid && !e_ir) || (m_ovr && !layer_start);
      m_sat = sat_set || (m_sat && !layer_start);
      if (bias_wr_en) bias_m[bias_wr_addr] = bias_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    acc_valid = 1'b1;
    acc_in = a;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic wbias(input logic [1:0] a, input logic [15:0] d);
    bias_wr_en = 1'b1; bias_wr_addr = a; bias_wr_data = d;
    tick();
    bias_wr_en = 1'b0;
  endtask

  task automatic chk_obs(input string name, input int k, input logic [15:0] d, input logic [1:0] i);
    if (k >= obs_d.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no output #%0d, want data %0h idx %0d", name, k, d, i);
    end else begin
      chk({name, "_data"}, obs_d[k], d);
      chk({name, "_idx"}, obs_i[k], i);
    end
  endtask

  int base, ld0, n_acc;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    wbias(2'd0, 16'h0100); wbias(2'd1, 16'h0000); wbias(2'd2, 16'h0000); wbias(2'd3, 16'h0000);
    tick();

    // Basic bias add and three-cycle latency.
    send(32'h0001_0000);
    @(negedge clk);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data", out_data, 16'h0200);
    chk("lat_idx", out_idx, 2'd0);
    repeat (4) tick();

    // Round half-up boundary.
    base = obs_d.size();
    send(32'h0000_0080);
    send(32'h0000_007F);
    repeat (6) tick();
    chk_obs("round_up", base, 16'h0001, 2'd1);
    chk_obs("round_down", base + 1, 16'h0000, 2'd2);

    // Positive saturation and negative result, index wraps 3 -> 0.
    wbias(2'd0, 16'h0000);
    base = obs_d.size();
    send(32'h7FFF_0000);
    send(32'hFFFF_0000);
    repeat (6) tick();
    chk_obs("sat_pos", base, 16'h7FFF, 2'd3);
`ifdef NEURON_RELU_EN
    chk_obs("neg", base + 1, 16'h0000, 2'd0);
`else
    chk_obs("neg", base + 1, 16'hFF00, 2'd0);
`endif
    chk("sat_sticky", sat_flag, 1'b1);

    // Back-pressure: only FIFO_DEPTH samples accepted, the rest dropped.
    out_ready = 1'b0;
    base = obs_d.size();
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      acc_valid = 1'b1;
      acc_in = 32'(k + 1) << 8;
      if (in_ready) n_acc++;
      tick();
    end
    acc_valid = 1'b0;
    tick();
    chk("bp_accepts", n_acc, 4);
    chk("bp_overrun", overrun_flag, 1'b1);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_held_data", out_data, 16'h0001);
    out_ready = 1'b1;
    repeat (8) tick();
    chk_obs("bp0", base, 16'h0001, 2'd1);
    chk_obs("bp1", base + 1, 16'h0002, 2'd2);
    chk_obs("bp2", base + 2, 16'h0003, 2'd3);
    chk_obs("bp3", base + 3, 16'h0004, 2'd0);
    chk("bp_count", obs_d.size() - base, 4);

    // layer_start clears flags; one full layer; bias write racing a read.
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("ls_sat_clr", sat_flag, 1'b0);
    chk("ls_ovr_clr", overrun_flag, 1'b0);
    ld0 = ld_cnt;
    base = obs_d.size();
    bias_wr_en = 1'b1; bias_wr_addr = 2'd0; bias_wr_data = 16'h0100;
    send(32'h0000_0000);
    bias_wr_en = 1'b0;
    send(32'h0000_0100);
    send(32'h0000_0200);
    send(32'h0000_0300);
    repeat (6) tick();
    chk_obs("layer0", base, 16'h0000, 2'd0);
    chk_obs("layer1", base + 1, 16'h0001, 2'd1);
    chk_obs("layer2", base + 2, 16'h0002, 2'd2);
    chk_obs("layer3", base + 3, 16'h0003, 2'd3);
    chk("layer_done_cnt", ld_cnt - ld0, 1);

    // layer_start concurrent with a sample restarts the index at 0.
    base = obs_d.size();
    send(32'h0000_0000);
    layer_start = 1'b1;
    send(32'h0000_0300);
    layer_start = 1'b0;
    send(32'h0000_0000);
    repeat (6) tick();
    chk_obs("ls_a", base, 16'h0100, 2'd0);
    chk_obs("ls_b", base + 1, 16'h0103, 2'd0);
    chk_obs("ls_c", base + 2, 16'h0000, 2'd1);

    // Reset with two samples in flight discards them.
    base = obs_d.size();
    send(32'h0000_0100);
    send(32'h0000_0200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (6) tick();
    chk("rst_no_stale", obs_d.size() - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
